// File: rtl/arbiter_requestor.sv
// Requestor-side endpoint: holds a request to a shared-resource arbiter for the
// whole of a local ready/valid burst, then backs off for a configurable hold-off.
module arbiter_requestor #(
    parameter int WORD_WIDTH     = 8,
    parameter int HOLDOFF_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  request,
    input  logic                  grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  grant_lost,
    output logic [1:0]            fsm_state,
    output logic [7:0]            holdoff_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANTED = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

    state_t     state_q;
    logic [7:0] count_q;
    logic       request_q;
    logic       lost_q;
    logic       enable;
    logic       handshake;
    logic       last_handshake;

    // Valid/ready: a beat moves in a cycle where in_valid and in_ready are both
    // high; out_valid/in_ready are the local pair gated by request & grant, and
    // a beat is never withdrawn by the bench-side sender once offered.
    assign enable         = request_q & grant;
    assign out_valid      = in_valid & enable;
    assign in_ready       = out_ready & enable;
    assign out_data       = in_data;
    assign out_last       = in_last;
    assign handshake      = in_valid & in_ready;
    assign last_handshake = handshake & in_last;

    assign request       = request_q;
    assign fsm_state     = state_q;
    assign holdoff_count = count_q;

    // The live term makes the error visible in the very cycle grant goes away.
    assign grant_lost = lost_q | ((state_q == GRANTED) & ~grant);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= 8'd0;
            request_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            if (state_q == GRANTED && !grant) begin
                lost_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= REQUEST;
                        request_q <= 1'b1;
                    end
                end
                REQUEST, GRANTED: begin
                    // request_q tracks the next state so it is a plain flop output.
                    if (last_handshake) begin
                        request_q <= 1'b0;
                        if (HOLDOFF_CYCLES > 0) begin
                            state_q <= HOLDOFF;
                            count_q <= HOLD_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (grant) begin
                        state_q <= GRANTED;
                    end
                end
                HOLDOFF: begin
                    if (count_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    request_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
